// File: rtl/packetmem_xbar_nbuf.sv
// Purpose: crossbar and ownership controller moving N_BUF packet buffers snooper -> CPU -> forwarder in arrival order.
// Latency: grants/releases commit on one clock edge; buffer datapath and agent read data/plen are combinational.
// Backpressure: an agent's ready stays low until a buffer is eligible; released buffers wait in index FIFOs of depth N_BUF.

// Purpose: small index FIFO holding buffer numbers waiting for the next agent.
// Latency: push visible at the head one edge later; head is read combinationally.
// Backpressure: never full in use, since every buffer index is queued at most once.
module packetmem_idx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop_rdy,
  output logic         o_head_vld,
  output logic [W-1:0] o_head_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_pop;

  assign o_head_vld = (r_cnt != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_pop      = i_pop_rdy && o_head_vld;

  // Circular storage with occupancy count; push and pop may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push_vld) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (i_push_vld && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!i_push_vld && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

module packetmem_xbar_nbuf #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int PLEN_WIDTH = 10,
  parameter int N_BUF      = 4,
  parameter int IDX_W      = $clog2(N_BUF)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       sn_addr,
  input  logic [DATA_WIDTH-1:0]       sn_wr_data,
  input  logic                        sn_wr_en,
  output logic                        sn_ready,
  input  logic                        sn_done,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic                        cpu_rd_en,
  output logic                        cpu_ready,
  input  logic                        cpu_done,
  input  logic                        cpu_accept,
  output logic [DATA_WIDTH-1:0]       cpu_rd_data,
  output logic [PLEN_WIDTH-1:0]       cpu_plen,
  input  logic [ADDR_WIDTH-1:0]       fwd_addr,
  input  logic                        fwd_rd_en,
  output logic                        fwd_ready,
  input  logic                        fwd_done,
  output logic [DATA_WIDTH-1:0]       fwd_rd_data,
  output logic [PLEN_WIDTH-1:0]       fwd_plen,
  output logic [N_BUF*ADDR_WIDTH-1:0] buf_addr,
  output logic [N_BUF*DATA_WIDTH-1:0] buf_wr_data,
  output logic [N_BUF-1:0]            buf_wr_en,
  output logic [N_BUF-1:0]            buf_rd_en,
  input  logic [N_BUF*DATA_WIDTH-1:0] buf_rd_data,
  input  logic [N_BUF*PLEN_WIDTH-1:0] buf_plen,
  output logic [15:0]                 drop_cnt,
  output logic [IDX_W:0]              free_cnt
);
  typedef enum logic [2:0] {
    ST_FREE, ST_SN, ST_RDY_CPU, ST_CPU, ST_RDY_FWD, ST_FWD
  } buf_st_e;

  buf_st_e          r_st     [N_BUF];
  buf_st_e          w_st_nxt [N_BUF];
  logic [IDX_W-1:0] r_sn_own, r_cpu_own, r_fwd_own;
  logic             r_sn_vld, r_cpu_vld, r_fwd_vld;
  logic [15:0]      r_drop_cnt;

  logic             w_sn_rel, w_cpu_rel, w_fwd_rel;
  logic             w_sn_gnt, w_cpu_gnt, w_fwd_gnt;
  logic             w_free_vld;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W:0]   w_free_cnt;
  logic             w_cpuq_vld, w_fwdq_vld;
  logic [IDX_W-1:0] w_cpuq_head, w_fwdq_head;

  // Done pulses only count while the agent actually holds a buffer.
  assign w_sn_rel  = sn_done  && r_sn_vld;
  assign w_cpu_rel = cpu_done && r_cpu_vld;
  assign w_fwd_rel = fwd_done && r_fwd_vld;

  // An agent releasing this edge may take a different, already-eligible buffer on the same edge.
  assign w_sn_gnt  = (!r_sn_vld  || w_sn_rel)  && w_free_vld;
  assign w_cpu_gnt = (!r_cpu_vld || w_cpu_rel) && w_cpuq_vld;
  assign w_fwd_gnt = (!r_fwd_vld || w_fwd_rel) && w_fwdq_vld;

  // Lowest-index FREE buffer and number of FREE buffers, both from pre-edge state.
  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    w_free_cnt = '0;
    for (int i = N_BUF - 1; i >= 0; i--) begin
      if (r_st[i] == ST_FREE) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
        w_free_cnt = w_free_cnt + 1'b1;
      end
    end
  end

  packetmem_idx_fifo #(.DEPTH(N_BUF), .W(IDX_W)) u_cpu_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_sn_rel),
    .i_push_dat (r_sn_own),
    .i_pop_rdy  (w_cpu_gnt),
    .o_head_vld (w_cpuq_vld),
    .o_head_dat (w_cpuq_head)
  );

  packetmem_idx_fifo #(.DEPTH(N_BUF), .W(IDX_W)) u_fwd_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_cpu_rel && cpu_accept),
    .i_push_dat (r_cpu_own),
    .i_pop_rdy  (w_fwd_gnt),
    .o_head_vld (w_fwdq_vld),
    .o_head_dat (w_fwdq_head)
  );

  // Per-buffer next state; every event touches a distinct buffer since their pre-edge states differ.
  always_comb begin
    for (int i = 0; i < N_BUF; i++) w_st_nxt[i] = r_st[i];
    if (w_sn_rel) w_st_nxt[r_sn_own] = ST_RDY_CPU;
    if (w_cpu_rel) begin
      if (cpu_accept) w_st_nxt[r_cpu_own] = ST_RDY_FWD;
      else            w_st_nxt[r_cpu_own] = ST_FREE;
    end
    if (w_fwd_rel) w_st_nxt[r_fwd_own]   = ST_FREE;
    if (w_sn_gnt)  w_st_nxt[w_free_idx]  = ST_SN;
    if (w_cpu_gnt) w_st_nxt[w_cpuq_head] = ST_CPU;
    if (w_fwd_gnt) w_st_nxt[w_fwdq_head] = ST_FWD;
  end

  // Buffer states, agent ownership and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BUF; i++) r_st[i] <= ST_FREE;
      r_sn_own   <= '0;
      r_cpu_own  <= '0;
      r_fwd_own  <= '0;
      r_sn_vld   <= 1'b0;
      r_cpu_vld  <= 1'b0;
      r_fwd_vld  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < N_BUF; i++) r_st[i] <= w_st_nxt[i];
      if (w_sn_gnt) begin
        r_sn_vld <= 1'b1;
        r_sn_own <= w_free_idx;
      end else if (w_sn_rel) begin
        r_sn_vld <= 1'b0;
      end
      if (w_cpu_gnt) begin
        r_cpu_vld <= 1'b1;
        r_cpu_own <= w_cpuq_head;
      end else if (w_cpu_rel) begin
        r_cpu_vld <= 1'b0;
      end
      if (w_fwd_gnt) begin
        r_fwd_vld <= 1'b1;
        r_fwd_own <= w_fwdq_head;
      end else if (w_fwd_rel) begin
        r_fwd_vld <= 1'b0;
      end
      if (w_cpu_rel && !cpu_accept && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Route each agent's port to the buffer it owns; unowned buffers see all zeros.
  always_comb begin
    buf_addr    = '0;
    buf_wr_data = '0;
    buf_wr_en   = '0;
    buf_rd_en   = '0;
    for (int i = 0; i < N_BUF; i++) begin
      if (r_sn_vld && (r_sn_own == IDX_W'(i))) begin
        buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH]    = sn_addr;
        buf_wr_data[i*DATA_WIDTH +: DATA_WIDTH] = sn_wr_data;
        buf_wr_en[i]                            = sn_wr_en;
      end else if (r_cpu_vld && (r_cpu_own == IDX_W'(i))) begin
        buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = cpu_addr;
        buf_rd_en[i]                         = cpu_rd_en;
      end else if (r_fwd_vld && (r_fwd_own == IDX_W'(i))) begin
        buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = fwd_addr;
        buf_rd_en[i]                         = fwd_rd_en;
      end
    end
  end

  assign sn_ready    = r_sn_vld;
  assign cpu_ready   = r_cpu_vld;
  assign fwd_ready   = r_fwd_vld;
  assign cpu_rd_data = r_cpu_vld ? buf_rd_data[r_cpu_own*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign cpu_plen    = r_cpu_vld ? buf_plen[r_cpu_own*PLEN_WIDTH +: PLEN_WIDTH]    : '0;
  assign fwd_rd_data = r_fwd_vld ? buf_rd_data[r_fwd_own*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign fwd_plen    = r_fwd_vld ? buf_plen[r_fwd_own*PLEN_WIDTH +: PLEN_WIDTH]    : '0;
  assign drop_cnt    = r_drop_cnt;
  assign free_cnt    = w_free_cnt;
endmodule

// File: tb/tb_packetmem_xbar_nbuf.sv
// Purpose: bench for packetmem_xbar_nbuf against a queue-based ownership model.
// Latency: outputs compared mid-cycle; model advances on each rising edge.
// Backpressure: agents stall by withholding done pulses.
module tb_packetmem_xbar_nbuf;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int PW = 10;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int M_FREE = 0, M_SN = 1, M_RC = 2, M_CPU = 3, M_RF = 4, M_FWD = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] sn_addr, cpu_addr, fwd_addr;
  logic [DW-1:0] sn_wr_data;
  logic sn_wr_en, sn_done, cpu_rd_en, cpu_done, cpu_accept, fwd_rd_en, fwd_done;
  logic sn_ready, cpu_ready, fwd_ready;
  logic [DW-1:0] cpu_rd_data, fwd_rd_data;
  logic [PW-1:0] cpu_plen, fwd_plen;
  logic [N*AW-1:0] buf_addr;
  logic [N*DW-1:0] buf_wr_data, buf_rd_data;
  logic [N-1:0] buf_wr_en, buf_rd_en;
  logic [N*PW-1:0] buf_plen;
  logic [15:0] drop_cnt;
  logic [IW:0] free_cnt;

  // Buffer contents and lengths seen by the DUT.
  logic [DW-1:0] mem [N][1<<AW];
  logic [PW-1:0] plen_v [N];

  // Reference model: buffer states, owner per agent (-1 = none), FIFOs of indices.
  int m_st [N];
  int m_sn, m_cpu, m_fwd, m_drop;
  int m_cq[$];
  int m_fq[$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_mem
    assign buf_rd_data[g*DW +: DW] = mem[g][buf_addr[g*AW +: AW]];
    assign buf_plen[g*PW +: PW]    = plen_v[g];
  end

  packetmem_xbar_nbuf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .N_BUF(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
    .sn_ready(sn_ready), .sn_done(sn_done),
    .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .cpu_accept(cpu_accept),
    .cpu_rd_data(cpu_rd_data), .cpu_plen(cpu_plen),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_ready(fwd_ready), .fwd_done(fwd_done),
    .fwd_rd_data(fwd_rd_data), .fwd_plen(fwd_plen),
    .buf_addr(buf_addr), .buf_wr_data(buf_wr_data), .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en),
    .buf_rd_data(buf_rd_data), .buf_plen(buf_plen),
    .drop_cnt(drop_cnt), .free_cnt(free_cnt)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = M_FREE;
    m_sn = -1; m_cpu = -1; m_fwd = -1; m_drop = 0;
    m_cq.delete();
    m_fq.delete();
  endtask

  function automatic int model_free();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == M_FREE) c++;
    return c;
  endfunction

  // Grants use pre-edge eligibility; releases apply first so an agent can swap buffers in one edge.
  task automatic model_step();
    int pf = -1;
    bit cq_ok, fq_ok;
    for (int i = N - 1; i >= 0; i--) if (m_st[i] == M_FREE) pf = i;
    cq_ok = (m_cq.size() > 0);
    fq_ok = (m_fq.size() > 0);
    if (sn_done && m_sn >= 0) begin
      m_st[m_sn] = M_RC; m_cq.push_back(m_sn); m_sn = -1;
    end
    if (cpu_done && m_cpu >= 0) begin
      if (cpu_accept) begin
        m_st[m_cpu] = M_RF; m_fq.push_back(m_cpu);
      end else begin
        m_st[m_cpu] = M_FREE;
        if (m_drop < 65535) m_drop++;
      end
      m_cpu = -1;
    end
    if (fwd_done && m_fwd >= 0) begin
      m_st[m_fwd] = M_FREE; m_fwd = -1;
    end
    if (m_sn < 0 && pf >= 0) begin m_sn = pf; m_st[pf] = M_SN; end
    if (m_cpu < 0 && cq_ok) begin m_cpu = m_cq.pop_front(); m_st[m_cpu] = M_CPU; end
    if (m_fwd < 0 && fq_ok) begin m_fwd = m_fq.pop_front(); m_st[m_fwd] = M_FWD; end
  endtask

  task automatic compare_all();
    logic [N*AW-1:0] e_addr = '0;
    logic [N*DW-1:0] e_wd = '0;
    logic [N-1:0] e_we = '0, e_re = '0;
    logic [DW-1:0] e_crd = '0, e_frd = '0;
    logic [PW-1:0] e_cpl = '0, e_fpl = '0;
    for (int i = 0; i < N; i++) begin
      if (m_sn == i) begin
        e_addr[i*AW +: AW] = sn_addr; e_wd[i*DW +: DW] = sn_wr_data; e_we[i] = sn_wr_en;
      end else if (m_cpu == i) begin
        e_addr[i*AW +: AW] = cpu_addr; e_re[i] = cpu_rd_en;
      end else if (m_fwd == i) begin
        e_addr[i*AW +: AW] = fwd_addr; e_re[i] = fwd_rd_en;
      end
    end
    if (m_cpu >= 0) begin e_crd = mem[m_cpu][cpu_addr]; e_cpl = plen_v[m_cpu]; end
    if (m_fwd >= 0) begin e_frd = mem[m_fwd][fwd_addr]; e_fpl = plen_v[m_fwd]; end
    check("sn_ready", sn_ready, m_sn >= 0);
    check("cpu_ready", cpu_ready, m_cpu >= 0);
    check("fwd_ready", fwd_ready, m_fwd >= 0);
    check("drop_cnt", drop_cnt, m_drop);
    check("free_cnt", free_cnt, model_free());
    check("buf_addr", buf_addr, e_addr);
    check("buf_wr_data", buf_wr_data, e_wd);
    check("buf_wr_en", buf_wr_en, e_we);
    check("buf_rd_en", buf_rd_en, e_re);
    check("cpu_rd_data", cpu_rd_data, e_crd);
    check("cpu_plen", cpu_plen, e_cpl);
    check("fwd_rd_data", fwd_rd_data, e_frd);
    check("fwd_plen", fwd_plen, e_fpl);
  endtask

  // One clock: compare mid-cycle, apply the snooper write to the buffer model, advance on the edge.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    if (m_sn >= 0 && sn_wr_en) mem[m_sn][sn_addr] = sn_wr_data;
    @(posedge clk);
    model_step();
    #1;
    sn_done = 1'b0; cpu_done = 1'b0; fwd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random pulses biased toward filling every agent; bounded by a cycle budget.
  task automatic wait_all_own(input string tag);
    for (int k = 0; k < 300 && !(m_sn >= 0 && m_cpu >= 0 && m_fwd >= 0); k++) begin
      sn_done    = 1'($urandom % 2);
      cpu_done   = ($urandom % 3) == 0;
      cpu_accept = 1'b1;
      fwd_done   = ($urandom % 4) == 0;
      cyc();
    end
    check(tag, {sn_ready, cpu_ready, fwd_ready}, 3'b111);
  endtask

  initial begin
    rst_n = 1'b0;
    sn_addr = '0; sn_wr_data = '0; sn_wr_en = 1'b0; sn_done = 1'b0;
    cpu_addr = '0; cpu_rd_en = 1'b0; cpu_done = 1'b0; cpu_accept = 1'b0;
    fwd_addr = '0; fwd_rd_en = 1'b0; fwd_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      plen_v[i] = PW'(60 + i);
      for (int a = 0; a < (1 << AW); a++) mem[i][a] = {32'(i), 32'(a)} ^ 64'h5A5A_0000_A5A5_0000;
    end
    model_reset();

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sn_ready", sn_ready, 1'b0);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_fwd_ready", fwd_ready, 1'b0);
    check("rst_free_cnt", free_cnt, 3'd4);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    check("rst_buf_addr", buf_addr, '0);
    check("rst_buf_en", {buf_wr_en, buf_rd_en}, 8'h00);
    check("rst_cpu_rd", {cpu_rd_data, cpu_plen}, '0);
    rst_n = 1'b1;
    cyc();

    // First grant: snooper on buf0 one cycle after release.
    sn_wr_en = 1'b1; sn_addr = 10'd5; sn_wr_data = 64'hDEAD_BEEF;
    #1;
    check("idle_sn_ready", sn_ready, 1'b1);
    check("idle_free_cnt", free_cnt, 3'd3);
    check("idle_buf_wr_en", buf_wr_en, 4'b0001);
    check("idle_buf_addr", buf_addr, 40'd5);
    check("idle_cpu_fwd", {cpu_ready, fwd_ready}, 2'b00);
    cyc();

    // Full pipeline on buf0.
    sn_wr_en = 1'b0; sn_addr = '0; sn_done = 1'b1;
    cyc();
    sn_wr_en = 1'b1;
    #1;
    check("pipe_sn_buf1", buf_wr_en, 4'b0010);
    sn_wr_en = 1'b0;
    cpu_addr = 10'd5; cpu_rd_en = 1'b1;
    cyc();
    check("pipe_cpu_ready", cpu_ready, 1'b1);
    check("pipe_cpu_plen", cpu_plen, 10'd60);
    check("pipe_cpu_data", cpu_rd_data, 64'hDEAD_BEEF);
    check("pipe_buf_rd_en", buf_rd_en, 4'b0001);
    cpu_done = 1'b1; cpu_accept = 1'b1;
    cyc();
    check("pipe_rdy_fwd", {cpu_ready, fwd_ready}, 2'b00);
    cyc();
    fwd_addr = 10'd5; fwd_rd_en = 1'b1;
    #1;
    check("pipe_fwd_ready", fwd_ready, 1'b1);
    check("pipe_fwd_data", fwd_rd_data, 64'hDEAD_BEEF);
    check("pipe_fwd_plen", fwd_plen, 10'd60);
    fwd_done = 1'b1;
    cyc();
    check("pipe_fwd_free", {fwd_ready, free_cnt}, {1'b0, 3'd3});

    // Three drops.
    for (int k = 0; k < 3; k++) begin
      sn_done = 1'b1;
      cyc();
      cyc();
      cpu_done = 1'b1; cpu_accept = 1'b0;
      cyc();
    end
    check("drop_cnt3", drop_cnt, 16'd3);
    check("drop_free", free_cnt, 3'd3);
    check("drop_no_fwd", fwd_ready, 1'b0);

    // Order under backpressure: CPU holds buf0 while the snooper fills the rest.
    do_reset();
    for (int i = 0; i < N; i++) plen_v[i] = PW'(10 + i);
    cyc();
    for (int k = 0; k < 4; k++) begin
      sn_done = 1'b1;
      cyc();
    end
    check("bp_sn_ready", sn_ready, 1'b0);
    check("bp_free_cnt", free_cnt, 3'd0);
    for (int k = 0; k < 4; k++) begin
      check("bp_order", cpu_plen, 10'(10 + k));
      cpu_done = 1'b1; cpu_accept = 1'b1;
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      fwd_done = 1'b1;
      cyc();
    end

    // Simultaneous release by all three agents.
    wait_all_own("simul_setup");
    sn_done = 1'b1; cpu_done = 1'b1; cpu_accept = 1'b1; fwd_done = 1'b1;
    cyc();
    compare_all();
    cyc();
    cyc();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      sn_addr    = AW'($urandom_range(0, 15));
      sn_wr_data = {$urandom, $urandom};
      sn_wr_en   = 1'($urandom % 2);
      sn_done    = ($urandom % 4) == 0;
      cpu_addr   = AW'($urandom_range(0, 15));
      cpu_rd_en  = 1'($urandom % 2);
      cpu_done   = ($urandom % 3) == 0;
      cpu_accept = 1'($urandom % 2);
      fwd_addr   = AW'($urandom_range(0, 15));
      fwd_rd_en  = 1'($urandom % 2);
      fwd_done   = ($urandom % 3) == 0;
      if ((k % 37) == 0) plen_v[k % N] = PW'($urandom);
      cyc();
    end

    // Asynchronous reset with every agent holding a buffer.
    wait_all_own("arst_setup");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {sn_ready, cpu_ready, fwd_ready}, 3'b000);
    check("arst_free", free_cnt, 3'd4);
    check("arst_drop", drop_cnt, 16'd0);
    check("arst_buf_en", {buf_wr_en, buf_rd_en}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
